alu_serie: RTL and testbench

//  Bit-serial WIDTH-bit ALU built around a 1-bit add/logic cell plus carry flip-flop.

---
 rtl/alu_serie_pkg.sv | 17 +
 rtl/alu_bit_cell.sv | 33 +++
 rtl/alu_serie.sv | 143 ++++++++++++++
 tb/tb_alu_serie.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_serie_pkg.sv
// alu_serie_pkg: shared constants for the bit-serial ALU.
//   OP_*   : operation select codes driven on the s input.
//   state_e: controller states (idle, shifting bits, result pulse).
package alu_serie_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_bit_cell.sv
// alu_bit_cell: combinational 1-bit ALU slice.
//   a, b  : operand bits (b already conditionally inverted upstream)
//   cin   : carry in (used by ADD only)
//   s     : op select (alu_serie_pkg::OP_*)
//   r     : result bit
//   cout  : carry out, 0 for logic ops
module alu_bit_cell
  import alu_serie_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] s,
  output logic       r,
  output logic       cout
);

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    case (s)
      OP_ADD: begin
        r    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_serie.sv
// alu_serie: bit-serial WIDTH-bit ALU, LSB first, one bit per clock.
//   clk, nreset : rising-edge clock, async active-low reset
//   start       : accept a/b/l/cin/s when not busy (IDLE or DONE)
//   a, b, l     : operands; l=1 inverts b before the cell (l=1,cin=1 -> A-B)
//   cin, s      : initial carry, op select (00 ADD, 01 AND, 10 OR, 11 XOR)
//   busy        : high while bits are shifting
//   done        : one-cycle result pulse
//   out, c_out  : result and final carry (c_out=0 for logic ops)
//   zero, ovf   : result==0 and signed overflow; present only when the
//                 ALU_SERIE_FLAGS_EN macro is defined
module alu_serie
  import alu_serie_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             l,
  input  logic             cin,
  input  logic [1:0]       s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             c_out
`ifdef ALU_SERIE_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, out_q, out_d;
  logic [1:0]         op_q, op_d;
  logic               carry_q, carry_d, c_out_q, c_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cell_r, cell_co, is_add;
`ifdef ALU_SERIE_FLAGS_EN
  logic               zero_q, zero_d, ovf_q, ovf_d;
`endif

  alu_bit_cell u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (op_q),
    .r    (cell_r),
    .cout (cell_co)
  );

  assign is_add = (op_q == OP_ADD);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    c_out_d = c_out_q;
`ifdef ALU_SERIE_FLAGS_EN
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          a_d     = a;
          b_d     = b ^ {WIDTH{l}};
          op_d    = s;
          carry_d = cin;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        out_d   = {cell_r, out_q[WIDTH-1:1]};
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = is_add ? cell_co : 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
          c_out_d = is_add ? cell_co : 1'b0;
`ifdef ALU_SERIE_FLAGS_EN
          zero_d  = (out_d == '0);
          // carry_q is the carry into the MSB position on this last bit
          ovf_d   = is_add & (carry_q ^ cell_co);
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      out_q   <= '0;
      c_out_q <= 1'b0;
`ifdef ALU_SERIE_FLAGS_EN
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      c_out_q <= c_out_d;
`ifdef ALU_SERIE_FLAGS_EN
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign out   = out_q;
  assign c_out = c_out_q;
`ifdef ALU_SERIE_FLAGS_EN
  assign zero  = zero_q;
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_alu_serie.sv
// tb_alu_serie: scoreboard bench for alu_serie (WIDTH=8). Stimulus pushes the
// reference result computed with plain integer arithmetic; an independent
// monitor pops and compares on every done pulse, including done timing.
module tb_alu_serie;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             c;
    logic             z;
    logic             v;
    int               k;
  } exp_t;

  logic             clk = 1'b0;
  logic             nreset = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic             l = 1'b0, cin = 1'b0;
  logic [1:0]       s = 2'b00;
  logic             busy, done, c_out;
  logic [WIDTH-1:0] dout;
`ifdef ALU_SERIE_FLAGS_EN
  logic             zero, ovf;
`endif

  alu_serie #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .nreset (nreset),
    .start  (start),
    .a      (a),
    .b      (b),
    .l      (l),
    .cin    (cin),
    .s      (s),
    .busy   (busy),
    .done   (done),
    .out    (dout),
    .c_out  (c_out)
`ifdef ALU_SERIE_FLAGS_EN
    ,
    .zero   (zero),
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   nchk = 0;
  int   npass = 0;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference model: whole-word arithmetic straight from the op definitions.
  function automatic exp_t model(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb_in,
                                 input logic ll, input logic cc, input logic [1:0] op);
    exp_t e;
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   sum;
    bb = ll ? ~bb_in : bb_in;
    e.c = 1'b0;
    e.v = 1'b0;
    case (op)
      2'b00: begin
        sum   = {1'b0, aa} + {1'b0, bb} + {{WIDTH{1'b0}}, cc};
        e.out = sum[WIDTH-1:0];
        e.c   = sum[WIDTH];
        e.v   = (aa[WIDTH-1] == bb[WIDTH-1]) && (e.out[WIDTH-1] != aa[WIDTH-1]);
      end
      2'b01:   e.out = aa & bb;
      2'b10:   e.out = aa | bb;
      default: e.out = aa ^ bb;
    endcase
    e.z = (e.out == '0);
    e.k = 0;
    return e;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nreset && done) begin
      chk("done_has_pending", 32'(q.size() > 0), 1);
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("out", 32'(dout), 32'(e.out));
        chk("c_out", 32'(c_out), 32'(e.c));
        chk("done_latency", cyc, e.k + WIDTH);
`ifdef ALU_SERIE_FLAGS_EN
        chk("zero", 32'(zero), 32'(e.z));
        chk("ovf", 32'(ovf), 32'(e.v));
`endif
      end
    end
  end

  task automatic drive(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic ll, input logic cc, input logic [1:0] op);
    a = aa; b = bb; l = ll; cin = cc; s = op;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() > 0 || busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 0);
    q.delete();
  endtask

  // Single operation issued from idle; inputs scrambled right after accept.
  task automatic do_op(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                       input logic ll, input logic cc, input logic [1:0] op);
    exp_t e;
    @(negedge clk);
    drive(aa, bb, ll, cc, op);
    start = 1'b1;
    e = model(aa, bb, ll, cc, op);
    e.k = cyc + 1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    drive(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));
    chk("busy_after_accept", 32'(busy), 1);
    wait_idle();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_out", 32'(dout), 0);
    chk("rst_c_out", 32'(c_out), 0);
`ifdef ALU_SERIE_FLAGS_EN
    chk("rst_zero", 32'(zero), 0);
    chk("rst_ovf", 32'(ovf), 0);
`endif
    repeat (2) @(negedge clk);
    nreset = 1'b1;

    // Directed vectors
    do_op(8'h35, 8'h4A, 1'b0, 1'b0, 2'b00);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 2'b00);
    do_op(8'h10, 8'h01, 1'b1, 1'b1, 2'b00);
    do_op(8'hF0, 8'h3C, 1'b0, 1'b0, 2'b01);
    do_op(8'hF0, 8'h3C, 1'b0, 1'b1, 2'b10);
    do_op(8'hF0, 8'h3C, 1'b0, 1'b1, 2'b11);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 2'b00);
    do_op(8'h80, 8'h01, 1'b1, 1'b1, 2'b00);

    // Randomized single operations
    for (int i = 0; i < 30; i++)
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom), 2'($urandom));

    // start re-pulsed mid-run must be ignored
    begin
      exp_t e;
      @(negedge clk);
      drive(8'h12, 8'h34, 1'b0, 1'b0, 2'b00);
      start = 1'b1;
      e = model(8'h12, 8'h34, 1'b0, 1'b0, 2'b00);
      e.k = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      drive(8'hAA, 8'h55, 1'b1, 1'b1, 2'b11);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
    end

    // Reset while processing bit 4: immediate abort, no done
    begin
      exp_t e;
      @(negedge clk);
      drive(8'h5A, 8'h33, 1'b0, 1'b1, 2'b00);
      start = 1'b1;
      e = model(8'h5A, 8'h33, 1'b0, 1'b1, 2'b00);
      e.k = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      nreset = 1'b0;
      q.delete();
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_out", 32'(dout), 0);
      chk("abort_done", 32'(done), 0);
      repeat (2) @(negedge clk);
      nreset = 1'b1;
      repeat (12) @(negedge clk);
      chk("abort_no_done_pending", q.size(), 0);
      do_op(8'h21, 8'h43, 1'b0, 1'b0, 2'b00);
    end

    // start held high through DONE: back-to-back operations
    begin
      int k;
      @(negedge clk);
      start = 1'b1;
      k = cyc + 1;
      for (int i = 0; i < 6; i++) begin
        exp_t e;
        logic [WIDTH-1:0] ra, rb;
        logic rl, rc;
        logic [1:0] rs;
        ra = WIDTH'($urandom); rb = WIDTH'($urandom);
        rl = 1'($urandom); rc = 1'($urandom); rs = 2'($urandom);
        drive(ra, rb, rl, rc, rs);
        e = model(ra, rb, rl, rc, rs);
        e.k = k;
        q.push_back(e);
        while (cyc < k) @(posedge clk);
        @(negedge clk);
        k = k + WIDTH + 1;
      end
      start = 1'b0;
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
